dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 8: maximum consecutive ext grants under lock; legal range 1..255.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 cpu_req, ext_req  input  1 each  access request from the CPU port and the external (loader/debug) port.
REQ-005 ext_lock  input  1  ext requests uninterrupted back-to-back grants.
REQ-006 cpu_we, ext_we  input  2 each  write enable, same encoding as the data memory MemWrite; 0 = read.
REQ-007 cpu_addr, ext_addr  input  32 each  byte address.
REQ-008 cpu_wdata, ext_wdata  input  32 each  write data.
REQ-009 cpu_len, ext_len  input  3 each  SB/SH/SW data-length code, passed through unchanged.
REQ-010 cpu_ack, ext_ack  output  1 each  access serviced this cycle.
REQ-011 cpu_rdata, ext_rdata  output  32 each  read data, valid during the matching ack cycle.
REQ-012 mem_addr  output  32  data memory address; the memory uses bits [8:2].
REQ-013 mem_we  output  2  data memory write enable.
REQ-014 mem_wdata  output  32  data memory write data.
REQ-015 mem_len  output  3  data memory write length.
REQ-016 mem_rdata  input  32  combinational read data from the data memory.

Function
REQ-017 The arbiter SHALL implement states IDLE, SRV_CPU and SRV_EXT, plus a last_owner bit and an 8-bit lock_cnt.
REQ-018 At each rising edge the arbiter SHALL pick the next state from the sampled cpu_req and ext_req.
  - Neither requesting -> IDLE.
  - One requesting -> that requester's SRV state.
  - Both requesting -> the requester that is not last_owner, except as overridden by REQ-019.
REQ-019 Lock override: if the current state is SRV_EXT, ext_req=1, ext_lock=1 and lock_cnt < LOCK_MAX, then ext SHALL win even when cpu_req=1.
REQ-020 lock_cnt SHALL count consecutive ext grants.
  - Set to 1 on an ext grant from any state other than SRV_EXT.
  - Increment, saturating at LOCK_MAX, on each further consecutive ext grant.
  - Clear to 0 on a CPU grant or on entering IDLE.
REQ-021 last_owner SHALL update on every grant to the granted requester and SHALL hold in IDLE.
REQ-022 Latency: a request sampled at edge N SHALL be serviced in cycle N+1, with the matching ack=1 and mem_* registered from the winner's fields at edge N.
REQ-023 Handshake: req, we, addr, wdata and len SHALL be held stable while req=1 and ack=0; a req still high during an ack cycle SHALL count as a new request, so the requester deasserts req in the ack cycle when it is done.
REQ-024 cpu_ack and ext_ack SHALL never be 1 in the same cycle; each ack SHALL be 1 exactly when the state is the matching SRV state.
REQ-025 cpu_rdata SHALL equal mem_rdata in SRV_CPU and 0 otherwise; ext_rdata likewise in SRV_EXT.
REQ-026 mem_we SHALL be 0 in IDLE; in IDLE mem_addr, mem_wdata and mem_len SHALL hold their last values.
REQ-027 The data memory commits a write at the edge that ends the SRV cycle, so each granted write SHALL assert mem_we for exactly one cycle.
REQ-028 When a requester wins back-to-back, SRV state SHALL be held with a new registered transfer each cycle, with no idle bubble.
REQ-029 A requester SHALL never be granted while its req=0.

Reset
REQ-030 While rstn=0, regardless of clock: state=IDLE, last_owner=EXT (so the CPU wins the first tie), lock_cnt=0, all outputs 0 (acks, mem_*, rdata); this SHALL apply mid-transfer.
REQ-031 After rstn rises, the first grant SHALL occur at the first rising edge with any req=1.

Verification
REQ-032 After reset, cpu_req=1, cpu_we=0, cpu_addr=0x10, mem_rdata=0x12345678 -> next cycle cpu_ack=1, mem_addr=0x10, mem_we=0, cpu_rdata=0x12345678, ext_ack=0.
REQ-033 cpu_req and ext_req both held 1, ext_lock=0, from reset -> grant sequence CPU, EXT, CPU, EXT, one grant per cycle, never both acks high.
REQ-034 LOCK_MAX=4, ext_lock=1, both req held 1, first grant to EXT -> EXT x4, CPU x1, EXT x4; lock_cnt reaches 4 and clears on the CPU grant.
REQ-035 ext_req=1, ext_we=2'b11, ext_addr=0x20, ext_wdata=0xDEADBEEF, ext_len=3'b100, req dropped in the ack cycle -> mem_we=2'b11 for exactly one cycle, mem_wdata=0xDEADBEEF, then IDLE with mem_we=0.
REQ-036 rstn pulsed low asynchronously during SRV_EXT with mem_we!=0 -> all outputs 0 before the next edge; after release, with both req=1, the first grant goes to CPU.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Signal bundle between the CPU port, the external loader/debug port and the
// data memory, as seen by dm_arbiter (slave) and by whoever drives it (master).
interface dm_arbiter_if;
  logic        cpu_req;
  logic        ext_req;
  logic        ext_lock;
  logic [1:0]  cpu_we;
  logic [1:0]  ext_we;
  logic [31:0] cpu_addr;
  logic [31:0] ext_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] ext_wdata;
  logic [2:0]  cpu_len;
  logic [2:0]  ext_len;
  logic        cpu_ack;
  logic        ext_ack;
  logic [31:0] cpu_rdata;
  logic [31:0] ext_rdata;
  logic [31:0] mem_addr;
  logic [1:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_len;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, ext_req, ext_lock, cpu_we, ext_we, cpu_addr, ext_addr,
           cpu_wdata, ext_wdata, cpu_len, ext_len, mem_rdata,
    output cpu_ack, ext_ack, cpu_rdata, ext_rdata,
           mem_addr, mem_we, mem_wdata, mem_len
  );

  modport master (
    output cpu_req, ext_req, ext_lock, cpu_we, ext_we, cpu_addr, ext_addr,
           cpu_wdata, ext_wdata, cpu_len, ext_len, mem_rdata,
    input  cpu_ack, ext_ack, cpu_rdata, ext_rdata,
           mem_addr, mem_we, mem_wdata, mem_len
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: round-robin between CPU and ext, with an
// optional bounded lock that lets ext keep the memory for LOCK_MAX grants.
module dm_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input  logic        clock,
  input  logic        rstn,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SRV_CPU = 2'd1,
    SRV_EXT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  localparam logic [7:0] LockMax = 8'(LOCK_MAX);

  state_e      state_q;
  state_e      state_d;
  owner_e      last_owner_q;
  logic [7:0]  lock_cnt_q;
  logic        cpu_ack_q;
  logic        ext_ack_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  mem_we_q;
  logic [2:0]  mem_len_q;
  logic        lock_hold;

  // Grant decision for the coming edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = IDLE;
    lock_hold = (state_q == SRV_EXT) && bus.ext_req && bus.ext_lock &&
                (lock_cnt_q < LockMax);
    if (bus.cpu_req && bus.ext_req) begin
      state_d = (lock_hold || (last_owner_q == OWN_CPU)) ? SRV_EXT : SRV_CPU;
    end else if (bus.cpu_req) begin
      state_d = SRV_CPU;
    end else if (bus.ext_req) begin
      state_d = SRV_EXT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_EXT;
      lock_cnt_q   <= '0;
      cpu_ack_q    <= 1'b0;
      ext_ack_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= '0;
      mem_len_q    <= '0;
    end else begin
      state_q   <= state_d;
      cpu_ack_q <= (state_d == SRV_CPU);
      ext_ack_q <= (state_d == SRV_EXT);
      case (state_d)
        SRV_CPU: begin
          last_owner_q <= OWN_CPU;
          lock_cnt_q   <= '0;
          mem_addr_q   <= bus.cpu_addr;
          mem_wdata_q  <= bus.cpu_wdata;
          mem_we_q     <= bus.cpu_we;
          mem_len_q    <= bus.cpu_len;
        end
        SRV_EXT: begin
          last_owner_q <= OWN_EXT;
          // Run length restarts on any fresh ext grant, saturates otherwise.
          if (state_q != SRV_EXT) begin
            lock_cnt_q <= 8'd1;
          end else if (lock_cnt_q < LockMax) begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
          end
          mem_addr_q  <= bus.ext_addr;
          mem_wdata_q <= bus.ext_wdata;
          mem_we_q    <= bus.ext_we;
          mem_len_q   <= bus.ext_len;
        end
        default: begin
          // Idle keeps address/data/length; only the write strobe drops.
          lock_cnt_q <= '0;
          mem_we_q   <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ext_ack   = ext_ack_q;
  assign bus.cpu_rdata = cpu_ack_q ? bus.mem_rdata : 32'h0;
  assign bus.ext_rdata = ext_ack_q ? bus.mem_rdata : 32'h0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_len   = mem_len_q;

endmodule
